// File: rtl/oled_text_console_if.sv
// Byte-stream input and OLED driver request bundle for oled_text_console.
// master = byte source plus driver side (testbench/system), slave = the console itself.
interface oled_text_console_if;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ROW_W  = 2;
   localparam int unsigned COL_W  = 4;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              drv_ready;
   logic              showchar;
   logic              clear;
   logic [DATA_W-1:0] charval;
   logic [ROW_W-1:0]  char_row;
   logic [COL_W-1:0]  char_col;
   logic              busy;

   modport master (
      output in_data, in_valid, drv_ready,
      input  in_ready, showchar, clear, charval, char_row, char_col, busy
   );

   modport slave (
      input  in_data, in_valid, drv_ready,
      output in_ready, showchar, clear, charval, char_row, char_col, busy
   );
endinterface

// File: rtl/oled_text_console.sv
// Byte FIFO + 4x16 cursor tracker feeding one showchar/clear request at a time to the OLED driver.
// Optional feature: define OLED_CONSOLE_BACKSPACE_EN to interpret 0x08 as a destructive backspace.
module oled_text_console #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   oled_text_console_if.slave bus
);

   localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ROW_W  = 2;
   localparam int unsigned COL_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE_C,
      S_ISSUE_K,
      S_ACK,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [DATA_W-1:0] cmd_q, cmd_d;
   logic [DATA_W-1:0] charval_q, charval_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              show_q, show_d;
   logic              clr_q, clr_d;
   logic              kind_clr_q, kind_clr_d;
   logic              no_adv_q, no_adv_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              empty, push;

   assign empty = (wr_q == rd_q);
   // in_ready_q always equals !full, so a push can never land on a full FIFO
   assign push  = bus.in_valid && in_ready_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_q[AW-1:0]] <= bus.in_data;
      end
   end

   // Next-state, cursor and request logic
   always_comb begin
      state_d    = state_q;
      wr_d       = push ? (wr_q + PW'(1)) : wr_q;
      rd_d       = rd_q;
      cmd_d      = cmd_q;
      charval_d  = charval_q;
      row_d      = row_q;
      col_d      = col_q;
      show_d     = 1'b0;
      clr_d      = 1'b0;
      kind_clr_d = kind_clr_q;
      no_adv_d   = no_adv_q;

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               cmd_d   = mem[rd_q[AW-1:0]];
               rd_d    = rd_q + PW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_IDLE;
            if (cmd_q inside {[8'h20:8'h7E]}) begin
               charval_d  = cmd_q;
               kind_clr_d = 1'b0;
               no_adv_d   = 1'b0;
               state_d    = S_ISSUE_C;
            end else begin
               case (cmd_q)
                  8'h0A: begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end
                  8'h0D: col_d = '0;
                  8'h0C: begin
                     kind_clr_d = 1'b1;
                     no_adv_d   = 1'b0;
                     state_d    = S_ISSUE_K;
                  end
`ifdef OLED_CONSOLE_BACKSPACE_EN
                  // Erase by drawing a space one column back; the cursor stays there
                  8'h08: begin
                     if (col_q != '0) begin
                        col_d      = col_q - COL_W'(1);
                        charval_d  = 8'h20;
                        kind_clr_d = 1'b0;
                        no_adv_d   = 1'b1;
                        state_d    = S_ISSUE_C;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_ISSUE_C: begin
            if (bus.drv_ready) begin
               show_d  = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ISSUE_K: begin
            if (bus.drv_ready) begin
               clr_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!bus.drv_ready) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.drv_ready) begin
               state_d = S_IDLE;
               if (kind_clr_q) begin
                  row_d = '0;
                  col_d = '0;
               end else if (!no_adv_q) begin
                  col_d = col_q + COL_W'(1);
                  if (col_q == COL_W'(15)) begin
                     row_d = row_q + ROW_W'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered status reflects the post-edge FIFO/FSM state
      in_ready_d = !((wr_d[PW-1] != rd_d[PW-1]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
      busy_d     = (wr_d != rd_d) || (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_q       <= '0;
         rd_q       <= '0;
         cmd_q      <= '0;
         charval_q  <= '0;
         row_q      <= '0;
         col_q      <= '0;
         show_q     <= 1'b0;
         clr_q      <= 1'b0;
         kind_clr_q <= 1'b0;
         no_adv_q   <= 1'b0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cmd_q      <= cmd_d;
         charval_q  <= charval_d;
         row_q      <= row_d;
         col_q      <= col_d;
         show_q     <= show_d;
         clr_q      <= clr_d;
         kind_clr_q <= kind_clr_d;
         no_adv_q   <= no_adv_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.showchar = show_q;
   assign bus.clear    = clr_q;
   assign bus.charval  = charval_q;
   assign bus.char_row = row_q;
   assign bus.char_col = col_q;
   assign bus.busy     = busy_q;

endmodule
